// File: rtl/dsp_reg_pkg.sv
// Shared types and constants for the DSP-side SPI register scheduler.
// The optional address range checking is enabled with DSP_REG_ADDR_CHECK_EN.
package dsp_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_POP,
    WR_EXEC,
    RD_POP,
    RD_EXEC,
    RD_PUSH
  } state_e;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_MAPPING = 1;
  localparam int CTRL_ERR_CLR = 7;

  localparam logic [7:0] ADDR_ERR_DATA = 8'hEE;

endpackage

// File: rtl/dsp_reg_bank.sv
// Register bank: storage, CTRL/STATUS decode, read mux and address range check.
// DSP_REG_ADDR_CHECK_EN adds the sticky out-of-range flag in STATUS bit2.
module dsp_reg_bank
  import dsp_reg_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              cfg_enable_o,
  output logic              cfg_mapping_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [DATA_W-1:0] CTRL_MASK = DATA_W'(3);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              cfg_enable_q;
  logic              cfg_mapping_q;
  logic              addr_err;
  logic              wr_in_range;
  logic              rd_in_range;
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;

  assign wr_in_range = (waddr_i < ADDR_W'(NUM_REGS));
  assign rd_in_range = (raddr_i < ADDR_W'(NUM_REGS));
  assign widx        = waddr_i[IDX_W-1:0];
  assign ridx        = raddr_i[IDX_W-1:0];

  // CTRL keeps only its two live bits; STATUS is never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i && wr_in_range) begin
      if (waddr_i == ADDR_W'(REG_CTRL)) begin
        mem_q[REG_CTRL] <= wdata_i & CTRL_MASK;
      end else if (waddr_i != ADDR_W'(REG_STATUS)) begin
        mem_q[widx] <= wdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_enable_q  <= 1'b0;
      cfg_mapping_q <= 1'b0;
    end else begin
      cfg_enable_q  <= mem_q[REG_CTRL][CTRL_ENABLE];
      cfg_mapping_q <= mem_q[REG_CTRL][CTRL_MAPPING];
    end
  end

`ifdef DSP_REG_ADDR_CHECK_EN
  localparam logic [DATA_W-1:0] OOR_DATA = DATA_W'(ADDR_ERR_DATA);
  logic err_q;

  // Setting wins over clearing; both cannot happen in the same cycle anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((we_i && !wr_in_range) || (re_i && !rd_in_range)) begin
      err_q <= 1'b1;
    end else if (we_i && (waddr_i == ADDR_W'(REG_CTRL)) && wdata_i[CTRL_ERR_CLR]) begin
      err_q <= 1'b0;
    end
  end

  assign addr_err = err_q;
`else
  localparam logic [DATA_W-1:0] OOR_DATA = '0;
  logic unused_re;

  assign unused_re = re_i;
  assign addr_err  = 1'b0;
`endif

  always_comb begin
    rdata_o = '0;
    if (!rd_in_range) begin
      rdata_o = OOR_DATA;
    end else if (raddr_i == ADDR_W'(REG_STATUS)) begin
      rdata_o[0] = cfg_enable_q;
      rdata_o[1] = cfg_mapping_q;
      rdata_o[2] = addr_err;
    end else begin
      rdata_o = mem_q[ridx];
    end
  end

  assign cfg_enable_o  = cfg_enable_q;
  assign cfg_mapping_o = cfg_mapping_q;

endmodule

// File: rtl/dsp_reg_scheduler.sv
// Drains the SPI write/read request FIFOs onto the local register bank with
// round-robin arbitration; DSP_REG_ADDR_CHECK_EN enables address error reporting.
module dsp_reg_scheduler
  import dsp_reg_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              waddr_empty,
  input  logic [ADDR_W-1:0] waddr_data,
  output logic              waddr_rd_en,
  input  logic              wdata_empty,
  input  logic [DATA_W-1:0] wdata_data,
  output logic              wdata_rd_en,
  input  logic              raddr_empty,
  input  logic [ADDR_W-1:0] raddr_data,
  output logic              raddr_rd_en,
  input  logic              rdata_full,
  output logic              rdata_wr_en,
  output logic [DATA_W-1:0] rdata_out,
  output logic              cfg_enable,
  output logic              cfg_mapping,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              last_was_write_q, last_was_write_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] bank_rdata;
  logic              wr_pend;
  logic              rd_pend;

  assign wr_pend = !waddr_empty && !wdata_empty;
  assign rd_pend = !raddr_empty && !rdata_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      last_was_write_q <= 1'b0;
      rdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      last_was_write_q <= last_was_write_d;
      if (state_q == RD_EXEC) rdata_q <= bank_rdata;
    end
  end

  // On a tie the type not served last wins, giving strict alternation.
  always_comb begin
    state_d          = state_q;
    last_was_write_d = last_was_write_q;
    case (state_q)
      IDLE: begin
        if (wr_pend && (!rd_pend || !last_was_write_q)) begin
          state_d          = WR_POP;
          last_was_write_d = 1'b1;
        end else if (rd_pend) begin
          state_d          = RD_POP;
          last_was_write_d = 1'b0;
        end
      end
      WR_POP:  state_d = WR_EXEC;
      WR_EXEC: state_d = IDLE;
      RD_POP:  state_d = RD_EXEC;
      RD_EXEC: state_d = RD_PUSH;
      RD_PUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign waddr_rd_en = (state_q == WR_POP);
  assign wdata_rd_en = (state_q == WR_POP);
  assign raddr_rd_en = (state_q == RD_POP);
  assign rdata_wr_en = (state_q == RD_PUSH);
  assign rdata_out   = rdata_q;
  assign busy        = (state_q != IDLE);

  dsp_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_bank (
    .clk           (clk),
    .rst_n         (rst_n),
    .we_i          (state_q == WR_EXEC),
    .waddr_i       (waddr_data),
    .wdata_i       (wdata_data),
    .re_i          (state_q == RD_EXEC),
    .raddr_i       (raddr_data),
    .rdata_o       (bank_rdata),
    .cfg_enable_o  (cfg_enable),
    .cfg_mapping_o (cfg_mapping)
  );

endmodule

// File: tb/tb_dsp_reg_scheduler.sv
// Self-checking bench for dsp_reg_scheduler: FIFO models, vector table,
// hand-written corner sequences and random traffic against a register model.
module tb_dsp_reg_scheduler;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 8;

`ifdef DSP_REG_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [7:0] OOR_VAL = CHK ? 8'hEE : 8'h00;
  localparam logic [7:0] ERR_BIT = CHK ? 8'h04 : 8'h00;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              waddr_empty = 1'b1;
  logic [ADDR_W-1:0] waddr_data = '0;
  logic              waddr_rd_en;
  logic              wdata_empty = 1'b1;
  logic [DATA_W-1:0] wdata_data = '0;
  logic              wdata_rd_en;
  logic              raddr_empty = 1'b1;
  logic [ADDR_W-1:0] raddr_data = '0;
  logic              raddr_rd_en;
  logic              rdata_full = 1'b0;
  logic              rdata_wr_en;
  logic [DATA_W-1:0] rdata_out;
  logic              cfg_enable;
  logic              cfg_mapping;
  logic              busy;

  dsp_reg_scheduler #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .waddr_empty (waddr_empty),
    .waddr_data  (waddr_data),
    .waddr_rd_en (waddr_rd_en),
    .wdata_empty (wdata_empty),
    .wdata_data  (wdata_data),
    .wdata_rd_en (wdata_rd_en),
    .raddr_empty (raddr_empty),
    .raddr_data  (raddr_data),
    .raddr_rd_en (raddr_rd_en),
    .rdata_full  (rdata_full),
    .rdata_wr_en (rdata_wr_en),
    .rdata_out   (rdata_out),
    .cfg_enable  (cfg_enable),
    .cfg_mapping (cfg_mapping),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // FIFO models: pushes are requested by the stimulus, everything else lives here.
  logic              pushW = 1'b0;
  logic [ADDR_W-1:0] pushWAddr = '0;
  logic [DATA_W-1:0] pushWData = '0;
  logic              pushR = 1'b0;
  logic [ADDR_W-1:0] pushRAddr = '0;
  logic [ADDR_W-1:0] wq[$];
  logic [DATA_W-1:0] dq[$];
  logic [ADDR_W-1:0] rq[$];

  always @(posedge clk) begin
    if (waddr_rd_en && wq.size() > 0) waddr_data <= wq.pop_front();
    if (wdata_rd_en && dq.size() > 0) wdata_data <= dq.pop_front();
    if (raddr_rd_en && rq.size() > 0) raddr_data <= rq.pop_front();
    if (pushW) begin
      wq.push_back(pushWAddr);
      dq.push_back(pushWData);
    end
    if (pushR) rq.push_back(pushRAddr);
    waddr_empty <= (wq.size() == 0);
    wdata_empty <= (dq.size() == 0);
    raddr_empty <= (rq.size() == 0);
  end

  // Passive monitor of grants and read results.
  int          wPulses = 0;
  int          rPulses = 0;
  int          pairErr = 0;
  bit          grantLog[$];
  logic [7:0]  rdLog[$];

  always @(posedge clk) begin
    if (waddr_rd_en) begin
      wPulses++;
      grantLog.push_back(1'b1);
    end
    if (raddr_rd_en) begin
      rPulses++;
      grantLog.push_back(1'b0);
    end
    if (waddr_rd_en !== wdata_rd_en) pairErr++;
    if (rdata_wr_en) rdLog.push_back(rdata_out);
  end

  // Behavioural register map.
  logic [7:0] mMem[NUM_REGS];
  logic [1:0] mCtrl;
  bit         mErr;

  function automatic void modelReset();
    for (int i = 0; i < NUM_REGS; i++) mMem[i] = 8'h00;
    mCtrl = 2'b00;
    mErr  = 1'b0;
  endfunction

  function automatic void modelWrite(input int a, input logic [7:0] d);
    if (a >= NUM_REGS) begin
      if (CHK) mErr = 1'b1;
    end else if (a == 0) begin
      mCtrl = d[1:0];
      if (CHK && d[7]) mErr = 1'b0;
    end else if (a != 1) begin
      mMem[a] = d;
    end
  endfunction

  function automatic logic [7:0] modelRead(input int a);
    if (a >= NUM_REGS) begin
      if (CHK) mErr = 1'b1;
      return OOR_VAL;
    end
    if (a == 0) return {6'b0, mCtrl};
    if (a == 1) return {5'b0, mErr, mCtrl};
    return mMem[a];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; holds the push request across one posedge.
  task automatic applyStimulus(input bit doW, input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd, input bit doR,
                               input logic [ADDR_W-1:0] ra);
    pushW = doW;
    pushWAddr = wa;
    pushWData = wd;
    pushR = doR;
    pushRAddr = ra;
    @(negedge clk);
    pushW = 1'b0;
    pushR = 1'b0;
  endtask

  task automatic doWrite(input int a, input logic [7:0] d);
    applyStimulus(1'b1, ADDR_W'(a), d, 1'b0, '0);
    repeat (6) @(negedge clk);
    modelWrite(a, d);
  endtask

  task automatic doRead(input int a, input logic [7:0] exp, input string name);
    int n;
    n = rdLog.size();
    applyStimulus(1'b0, '0, '0, 1'b1, ADDR_W'(a));
    for (int i = 0; i < 20 && rdLog.size() == n; i++) @(negedge clk);
    if (rdLog.size() == n) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: no read result within 20 cycles, expected 0x%0h", name, exp);
    end else begin
      checkOutput(name, 32'(rdLog[n]), 32'(exp));
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    @(negedge clk);
  endtask

  typedef struct {
    bit         isWrite;
    int         addr;
    logic [7:0] data;
    logic [7:0] expRead;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int         n, g0, w0, r0, seenAt, a;
    logic [7:0] d, e;
    bit         expGrant[6];
    logic [7:0] expRd[3];

    vecs[0]  = '{1'b1, 'h000, 8'h03, 8'h00};
    vecs[1]  = '{1'b0, 'h000, 8'h00, 8'h03};
    vecs[2]  = '{1'b0, 'h001, 8'h00, 8'h03};
    vecs[3]  = '{1'b1, 'h005, 8'hA5, 8'h00};
    vecs[4]  = '{1'b0, 'h005, 8'h00, 8'hA5};
    vecs[5]  = '{1'b1, 'h001, 8'hFF, 8'h00};
    vecs[6]  = '{1'b0, 'h001, 8'h00, 8'h03};
    vecs[7]  = '{1'b1, 'h00F, 8'h5A, 8'h00};
    vecs[8]  = '{1'b0, 'h00F, 8'h00, 8'h5A};
    vecs[9]  = '{1'b1, 'h010, 8'h77, 8'h00};
    vecs[10] = '{1'b0, 'h010, 8'h00, OOR_VAL};
    vecs[11] = '{1'b0, 'h001, 8'h00, 8'h03 | ERR_BIT};
    vecs[12] = '{1'b1, 'h000, 8'h83, 8'h00};
    vecs[13] = '{1'b0, 'h001, 8'h00, 8'h03};
    vecs[14] = '{1'b0, 'h3FF, 8'h00, OOR_VAL};
    vecs[15] = '{1'b0, 'h001, 8'h00, 8'h03 | ERR_BIT};
    vecs[16] = '{1'b1, 'h000, 8'h80, 8'h00};
    vecs[17] = '{1'b0, 'h000, 8'h00, 8'h00};
    vecs[18] = '{1'b0, 'h001, 8'h00, 8'h00};

    modelReset();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_enables", {28'b0, waddr_rd_en, wdata_rd_en, raddr_rd_en, rdata_wr_en}, 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_cfg", {30'b0, cfg_mapping, cfg_enable}, 32'h0);
    checkOutput("reset_rdata_out", 32'(rdata_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].isWrite) begin
        doWrite(vecs[i].addr, vecs[i].data);
      end else begin
        e = modelRead(vecs[i].addr);
        doRead(vecs[i].addr, vecs[i].expRead, $sformatf("vec%0d_read_0x%0h", i, vecs[i].addr));
      end
    end
    checkOutput("cfg_after_ctrl_clear", {30'b0, cfg_mapping, cfg_enable}, 32'h0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, NUM_REGS + 3);
      if ($urandom_range(0, 9) == 0) a = 'h3FF;
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        doWrite(a, d);
      end else begin
        e = modelRead(a);
        doRead(a, e, $sformatf("rand%0d_read_0x%0h", i, a));
      end
    end

    // Reset in the middle of a read.
    doWrite(0, 8'h03);
    checkOutput("cfg_after_write_03", {30'b0, cfg_mapping, cfg_enable}, 32'h3);
    n = rdLog.size();
    applyStimulus(1'b0, '0, '0, 1'b1, ADDR_W'(5));
    for (int i = 0; i < 10 && !raddr_rd_en; i++) @(negedge clk);
    checkOutput("abort_read_started", 32'(raddr_rd_en), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_enables", {28'b0, waddr_rd_en, wdata_rd_en, raddr_rd_en, rdata_wr_en}, 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_cfg", {30'b0, cfg_mapping, cfg_enable}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    repeat (10) @(negedge clk);
    checkOutput("abort_no_push", 32'(rdLog.size()), 32'(n));

    // Contention straight out of reset: write wins first, then strict alternation.
    g0 = grantLog.size();
    n  = rdLog.size();
    applyStimulus(1'b1, ADDR_W'(2), 8'h11, 1'b1, ADDR_W'(2));
    applyStimulus(1'b1, ADDR_W'(3), 8'h22, 1'b1, ADDR_W'(3));
    applyStimulus(1'b1, ADDR_W'(4), 8'h33, 1'b1, ADDR_W'(4));
    repeat (40) @(negedge clk);
    modelWrite(2, 8'h11);
    modelWrite(3, 8'h22);
    modelWrite(4, 8'h33);
    expGrant = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    expRd    = '{8'h11, 8'h22, 8'h33};
    checkOutput("contention_grant_count", 32'(grantLog.size() - g0), 32'd6);
    checkOutput("contention_read_count", 32'(rdLog.size() - n), 32'd3);
    for (int i = 0; i < 6; i++)
      if (g0 + i < grantLog.size())
        checkOutput($sformatf("contention_grant%0d_is_write", i), 32'(grantLog[g0 + i]), 32'(expGrant[i]));
    for (int i = 0; i < 3; i++)
      if (n + i < rdLog.size())
        checkOutput($sformatf("contention_read%0d", i), 32'(rdLog[n + i]), 32'(expRd[i]));

    // Read FIFO full: reads stall, writes still flow.
    rdata_full = 1'b1;
    w0 = wPulses;
    r0 = rPulses;
    n  = rdLog.size();
    applyStimulus(1'b0, '0, '0, 1'b1, ADDR_W'(3));
    applyStimulus(1'b1, ADDR_W'(6), 8'h66, 1'b0, '0);
    applyStimulus(1'b1, ADDR_W'(7), 8'h77, 1'b0, '0);
    repeat (20) @(negedge clk);
    modelWrite(6, 8'h66);
    modelWrite(7, 8'h77);
    checkOutput("full_no_read_pop", 32'(rPulses - r0), 32'd0);
    checkOutput("full_writes_done", 32'(wPulses - w0), 32'd2);
    rdata_full = 1'b0;
    seenAt = 0;
    for (int i = 1; i <= 3 && seenAt == 0; i++) begin
      @(negedge clk);
      if (raddr_rd_en) seenAt = i;
    end
    checkOutput("full_release_latency", 32'(seenAt), 32'd1);
    repeat (6) @(negedge clk);
    checkOutput("full_read_count", 32'(rdLog.size() - n), 32'd1);
    if (rdLog.size() > n) checkOutput("full_read_value", 32'(rdLog[n]), 32'(modelRead(3)));
    doRead(6, modelRead(6), "read_after_full_reg6");

    checkOutput("pop_pairing", 32'(pairErr), 32'd0);
    checkOutput("busy_idle_at_end", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
